unidad_control_multiciclo: RTL and testbench

Multicycle sequencer for the RV32I subset datapath (R-type, LW, SW, BEQ). It replaces single-cycle control by stepping one shared memory port and one ALU through fetch, decode, execute, memory and writeback states. It stalls on a memory ready handshake and traps on illegal opcodes or memory timeouts. It sits between the instruction register / ALU zero flag and the datapath muxes and write enables.

---
 rtl/unidad_control_multiciclo.sv | 220 ++++++++++++++++++++++
 tb/tb_unidad_control_multiciclo.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_control_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : unidad_control_multiciclo
// Description : Multicycle control sequencer for an RV32I subset datapath
//               (R-type, LW, SW, BEQ). Steps a shared memory port and one ALU
//               through fetch/decode/execute/memory/writeback, stalls on the
//               memory ready handshake and traps on illegal opcodes or on
//               memory accesses that exceed the wait budget.
// Revision    : 1.0 - initial release
// ============================================================================
module unidad_control_multiciclo #(
    parameter int TIMEOUT_CICLOS = 15,
    parameter int W_CNT          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_listo,
    output logic             ir_escritura,
    output logic             pc_escritura,
    output logic             pc_fuente,
    output logic             i_o_d,
    output logic             mem_lectura,
    output logic             mem_escritura,
    output logic [1:0]       alu_op,
    output logic             alu_fuente,
    output logic             reg_escritura,
    output logic             mem_a_reg,
    output logic [2:0]       estado,
    output logic             error,
    output logic [W_CNT-1:0] instr_retiradas
);

    // The wait counter only needs to reach TIMEOUT_CICLOS-1: at that value a
    // further cycle without mem_listo traps instead of counting.
    localparam int W_ESPERA = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [W_ESPERA-1:0] ESPERA_MAX = W_ESPERA'(TIMEOUT_CICLOS - 1);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        ST_INACTIVO  = 3'd0,
        ST_BUSQUEDA  = 3'd1,
        ST_DECODIF   = 3'd2,
        ST_EJECUTA   = 3'd3,
        ST_MEMORIA   = 3'd4,
        ST_ESCRITURA = 3'd5,
        ST_ERROR     = 3'd6
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [W_ESPERA-1:0] espera_q, espera_d;
    logic                primera_q, primera_d;
    logic [W_CNT-1:0]    retiradas_q, retiradas_d;

    logic es_r, es_lw, es_sw, es_beq, es_legal;
    logic espera_agotada;
    logic cancela_busqueda;
    logic retira;

    assign es_r     = (opcode == OP_R);
    assign es_lw    = (opcode == OP_LW);
    assign es_sw    = (opcode == OP_SW);
    assign es_beq   = (opcode == OP_BEQ);
    assign es_legal = es_r | es_lw | es_sw | es_beq;

    // The last permitted wait cycle still lets a same-cycle mem_listo win.
    assign espera_agotada = (espera_q == ESPERA_MAX) && !mem_listo;

    // inicio is only honoured on the first BUSQUEDA cycle; dropping it there
    // abandons the fetch before any memory strobe is raised.
    assign cancela_busqueda = primera_q && !inicio;

    // Next-state selection and retire detection.
    always_comb begin
        estado_d = estado_q;
        retira   = 1'b0;
        case (estado_q)
            ST_INACTIVO: begin
                if (inicio) estado_d = ST_BUSQUEDA;
            end
            ST_BUSQUEDA: begin
                if (cancela_busqueda)    estado_d = ST_INACTIVO;
                else if (mem_listo)      estado_d = ST_DECODIF;
                else if (espera_agotada) estado_d = ST_ERROR;
            end
            ST_DECODIF: begin
                estado_d = es_legal ? ST_EJECUTA : ST_ERROR;
            end
            ST_EJECUTA: begin
                if (es_r) begin
                    estado_d = ST_ESCRITURA;
                end else if (es_lw || es_sw) begin
                    estado_d = ST_MEMORIA;
                end else if (es_beq) begin
                    estado_d = ST_BUSQUEDA;
                    retira   = 1'b1;
                end else begin
                    // opcode changed under the instruction: treat as a trap
                    estado_d = ST_ERROR;
                end
            end
            ST_MEMORIA: begin
                if (mem_listo) begin
                    if (es_lw) begin
                        estado_d = ST_ESCRITURA;
                    end else begin
                        estado_d = ST_BUSQUEDA;
                        retira   = 1'b1;
                    end
                end else if (espera_agotada) begin
                    estado_d = ST_ERROR;
                end
            end
            ST_ESCRITURA: begin
                estado_d = ST_BUSQUEDA;
                retira   = 1'b1;
            end
            ST_ERROR: begin
                estado_d = ST_ERROR;
            end
            default: begin
                estado_d = ST_INACTIVO;
            end
        endcase
    end

    // Wait counter, fetch-entry flag and retire counter next values.
    always_comb begin
        espera_d    = espera_q;
        primera_d   = (estado_d == ST_BUSQUEDA) && (estado_q != ST_BUSQUEDA);
        retiradas_d = retiradas_q;
        if (estado_d != estado_q) begin
            espera_d = '0;
        end else if ((estado_q == ST_BUSQUEDA || estado_q == ST_MEMORIA) && !mem_listo) begin
            espera_d = espera_q + W_ESPERA'(1);
        end
        if (retira) retiradas_d = retiradas_q + W_CNT'(1);
    end

    // All sequencer state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= ST_INACTIVO;
            espera_q    <= '0;
            primera_q   <= 1'b0;
            retiradas_q <= '0;
        end else begin
            estado_q    <= estado_d;
            espera_q    <= espera_d;
            primera_q   <= primera_d;
            retiradas_q <= retiradas_d;
        end
    end

    // Datapath controls decoded from the current state, qualified by
    // mem_listo, zero and the opcode class.
    always_comb begin
        ir_escritura  = 1'b0;
        pc_escritura  = 1'b0;
        pc_fuente     = 1'b0;
        i_o_d         = 1'b0;
        mem_lectura   = 1'b0;
        mem_escritura = 1'b0;
        alu_op        = ALU_ADD;
        alu_fuente    = 1'b0;
        reg_escritura = 1'b0;
        mem_a_reg     = 1'b0;
        case (estado_q)
            ST_BUSQUEDA: begin
                if (!cancela_busqueda) begin
                    mem_lectura = 1'b1;
                    if (mem_listo) begin
                        ir_escritura = 1'b1;
                        pc_escritura = 1'b1;
                    end
                end
            end
            ST_EJECUTA: begin
                if (es_r) begin
                    alu_op = ALU_FUNCT;
                end else if (es_lw || es_sw) begin
                    alu_op     = ALU_ADD;
                    alu_fuente = 1'b1;
                end else if (es_beq) begin
                    alu_op       = ALU_SUB;
                    pc_fuente    = 1'b1;
                    pc_escritura = zero;
                end
            end
            ST_MEMORIA: begin
                i_o_d         = 1'b1;
                alu_fuente    = 1'b1;
                mem_lectura   = es_lw;
                mem_escritura = es_sw;
            end
            ST_ESCRITURA: begin
                reg_escritura = 1'b1;
                mem_a_reg     = es_lw;
            end
            default: begin
            end
        endcase
    end

    assign estado          = estado_q;
    assign error           = (estado_q == ST_ERROR);
    assign instr_retiradas = retiradas_q;

endmodule
`default_nettype wire

// File: tb/tb_unidad_control_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidad_control_multiciclo
// Description : Self-checking bench for the multicycle control sequencer.
//               Each instruction is expanded into its expected per-cycle state
//               list from the instruction-class rules; expected controls are
//               looked up per state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidad_control_multiciclo;

    localparam int T = 4;
    localparam int W = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_ILL = 7'b0010011;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inicio;
    logic [6:0]   opcode;
    logic         zero;
    logic         mem_listo;
    logic         ir_escritura, pc_escritura, pc_fuente, i_o_d;
    logic         mem_lectura, mem_escritura;
    logic [1:0]   alu_op;
    logic         alu_fuente, reg_escritura, mem_a_reg;
    logic [2:0]   estado;
    logic         error;
    logic [W-1:0] instr_retiradas;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;
    int paso_n  = 0;

    typedef struct {
        logic [2:0] st;
        bit         listo;
        bit         ini;
        logic [6:0] op;
        bit         z;
        bit         first;
        bit         ret;
    } paso_t;

    paso_t plan[$];

    unidad_control_multiciclo #(
        .TIMEOUT_CICLOS(T),
        .W_CNT         (W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inicio         (inicio),
        .opcode         (opcode),
        .zero           (zero),
        .mem_listo      (mem_listo),
        .ir_escritura   (ir_escritura),
        .pc_escritura   (pc_escritura),
        .pc_fuente      (pc_fuente),
        .i_o_d          (i_o_d),
        .mem_lectura    (mem_lectura),
        .mem_escritura  (mem_escritura),
        .alu_op         (alu_op),
        .alu_fuente     (alu_fuente),
        .reg_escritura  (reg_escritura),
        .mem_a_reg      (mem_a_reg),
        .estado         (estado),
        .error          (error),
        .instr_retiradas(instr_retiradas)
    );

    always #5 clk = ~clk;

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    // Control vector {ir,pcw,pcf,iod,mr,mw,aluop[1:0],alus,regw,m2r}
    function automatic logic [10:0] observado();
        return {ir_escritura, pc_escritura, pc_fuente, i_o_d, mem_lectura,
                mem_escritura, alu_op, alu_fuente, reg_escritura, mem_a_reg};
    endfunction

    // Reference control table indexed by state and instruction class.
    function automatic logic [10:0] esperado(paso_t p);
        logic ir, pcw, pcf, iod, mr, mw, als, rw, m2r;
        logic [1:0] aop;
        {ir, pcw, pcf, iod, mr, mw, als, rw, m2r} = '0;
        aop = 2'b00;
        case (p.st)
            3'd1: if (!(p.first && !p.ini)) begin
                mr = 1'b1;
                if (p.listo) begin ir = 1'b1; pcw = 1'b1; end
            end
            3'd3: begin
                if (p.op == OP_R) aop = 2'b10;
                else if (p.op == OP_LW || p.op == OP_SW) begin aop = 2'b00; als = 1'b1; end
                else begin aop = 2'b01; pcf = 1'b1; pcw = p.z; end
            end
            3'd4: begin
                iod = 1'b1; als = 1'b1;
                mr = (p.op == OP_LW); mw = (p.op == OP_SW);
            end
            3'd5: begin rw = 1'b1; m2r = (p.op == OP_LW); end
            default: ;
        endcase
        return {ir, pcw, pcf, iod, mr, mw, aop, als, rw, m2r};
    endfunction

    task automatic push(logic [2:0] st, bit listo, bit ini, logic [6:0] op, bit z, bit first, bit ret);
        paso_t p;
        p.st = st; p.listo = listo; p.ini = ini; p.op = op;
        p.z = z; p.first = first; p.ret = ret;
        plan.push_back(p);
    endtask

    task automatic add_start(logic [6:0] op);
        push(3'd0, rb(), 1'b1, op, rb(), 1'b0, 1'b0);
    endtask

    task automatic add_fetch(logic [6:0] op, int waits);
        for (int i = 0; i <= waits; i++)
            push(3'd1, (i == waits), 1'b1, op, rb(), (i == 0), 1'b0);
    endtask

    // Expand one instruction into its expected per-cycle states.
    task automatic add_instr(logic [6:0] op, bit z, int wf, int wm);
        add_fetch(op, wf);
        push(3'd2, rb(), 1'b1, op, rb(), 1'b0, 1'b0);
        if (op == OP_R) begin
            push(3'd3, rb(), 1'b1, op, rb(), 1'b0, 1'b0);
            push(3'd5, rb(), 1'b1, op, rb(), 1'b0, 1'b1);
        end else if (op == OP_LW) begin
            push(3'd3, rb(), 1'b1, op, rb(), 1'b0, 1'b0);
            for (int i = 0; i <= wm; i++)
                push(3'd4, (i == wm), 1'b1, op, rb(), 1'b0, 1'b0);
            push(3'd5, rb(), 1'b1, op, rb(), 1'b0, 1'b1);
        end else if (op == OP_SW) begin
            push(3'd3, rb(), 1'b1, op, rb(), 1'b0, 1'b0);
            for (int i = 0; i <= wm; i++)
                push(3'd4, (i == wm), 1'b1, op, rb(), 1'b0, (i == wm));
        end else begin
            push(3'd3, rb(), 1'b1, op, z, 1'b0, 1'b1);
        end
    endtask

    // Drop inicio at fetch entry: no access, back to idle.
    task automatic add_stop(logic [6:0] op);
        push(3'd1, rb(), 1'b0, op, rb(), 1'b1, 1'b0);
        push(3'd0, rb(), 1'b0, op, rb(), 1'b0, 1'b0);
    endtask

    task automatic run_plan(string nombre);
        paso_t p;
        while (plan.size() > 0) begin
            p = plan.pop_front();
            @(negedge clk);
            inicio = p.ini; opcode = p.op; zero = p.z; mem_listo = p.listo;
            #1;
            paso_n++;
            n_tests++;
            if (estado !== p.st) begin
                n_fail++;
                $display("FAIL %s estado step %0d: got %0d expected %0d", nombre, paso_n, estado, p.st);
            end
            n_tests++;
            if (observado() !== esperado(p)) begin
                n_fail++;
                $display("FAIL %s controls step %0d: got %b expected %b", nombre, paso_n, observado(), esperado(p));
            end
            n_tests++;
            if (error !== (p.st == 3'd6)) begin
                n_fail++;
                $display("FAIL %s error step %0d: got %b expected %b", nombre, paso_n, error, (p.st == 3'd6));
            end
            n_tests++;
            if (instr_retiradas !== W'(exp_cnt)) begin
                n_fail++;
                $display("FAIL %s retired step %0d: got %0d expected %0d", nombre, paso_n, instr_retiradas, exp_cnt);
            end
            if (p.ret) exp_cnt = (exp_cnt + 1) % (1 << W);
        end
    endtask

    task automatic check_reset_values(string nombre);
        n_tests++;
        if (estado !== 3'd0 || error !== 1'b0 || instr_retiradas !== '0 || observado() !== '0) begin
            n_fail++;
            $display("FAIL %s reset values: got estado=%0d error=%b cnt=%0d ctl=%b expected 0 0 0 0",
                     nombre, estado, error, instr_retiradas, observado());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; inicio = 1'b0; opcode = '0; zero = 1'b0; mem_listo = 1'b0;
        @(negedge clk);
        #1;
        check_reset_values("reset");
        rst_n  = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_rtype();
        do_reset();
        add_start(OP_R);
        add_instr(OP_R, 1'b0, 0, 0);
        add_stop(OP_R);
        run_plan("rtype");
    endtask

    task automatic test_lw_wait();
        do_reset();
        add_start(OP_LW);
        add_instr(OP_LW, 1'b0, 0, 3);
        add_stop(OP_LW);
        run_plan("lw_wait");
    endtask

    task automatic test_beq();
        do_reset();
        add_start(OP_BEQ);
        add_instr(OP_BEQ, 1'b1, 0, 0);
        add_instr(OP_BEQ, 1'b0, 0, 0);
        add_stop(OP_BEQ);
        run_plan("beq");
    endtask

    task automatic test_illegal();
        do_reset();
        add_start(OP_ILL);
        add_fetch(OP_ILL, 0);
        push(3'd2, rb(), 1'b1, OP_ILL, rb(), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            push(3'd6, rb(), 1'b1, OP_ILL, rb(), 1'b0, 1'b0);
        run_plan("illegal");
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("illegal_rst");
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        add_start(OP_SW);
        add_fetch(OP_SW, 0);
        push(3'd2, rb(), 1'b1, OP_SW, rb(), 1'b0, 1'b0);
        push(3'd3, rb(), 1'b1, OP_SW, rb(), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            push(3'd4, 1'b0, 1'b1, OP_SW, rb(), 1'b0, 1'b0);
        push(3'd6, rb(), 1'b1, OP_SW, rb(), 1'b0, 1'b0);
        push(3'd6, rb(), 1'b1, OP_SW, rb(), 1'b0, 1'b0);
        run_plan("timeout");
        do_reset();
        add_start(OP_SW);
        add_instr(OP_SW, 1'b0, 3, 3);
        add_stop(OP_SW);
        run_plan("timeout_edge");
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_start(OP_SW);
        add_fetch(OP_SW, 0);
        push(3'd2, rb(), 1'b1, OP_SW, rb(), 1'b0, 1'b0);
        push(3'd3, rb(), 1'b1, OP_SW, rb(), 1'b0, 1'b0);
        push(3'd4, 1'b0, 1'b1, OP_SW, rb(), 1'b0, 1'b0);
        push(3'd4, 1'b0, 1'b1, OP_SW, rb(), 1'b0, 1'b0);
        run_plan("reset_mid");
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (mem_escritura !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid mem_escritura: got %b expected 0", mem_escritura);
        end
        check_reset_values("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [4];
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;
        do_reset();
        add_start(OP_R);
        for (int i = 0; i < 30; i++)
            add_instr(ops[$urandom_range(0, 3)], rb(), $urandom_range(0, 3), $urandom_range(0, 3));
        add_stop(OP_R);
        run_plan("back_to_back");
    endtask

    initial begin
        rst_n = 1'b0; inicio = 1'b0; opcode = '0; zero = 1'b0; mem_listo = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
